// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Arbitrates four requesters that want to write one shared WIDTH-bit register.
// A round-robin arbiter picks one requester in IDLE and registers a one-hot
// grant. The write is committed at the edge that ends the single-cycle GRANT
// state. An optional HOLD guard of HOLD_CYC idle cycles follows every write.
//
// Parameters
//   WIDTH     data width of the shared register
//   HOLD_CYC  guard cycles after each write (0..15)
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   req    in   [3:0]  per-requester write request
//   wdata  in   [4*WIDTH-1:0]  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    out  [3:0]  registered one-hot grant (high only during GRANT)
//   q      out  [WIDTH-1:0]  shared register contents
//   q_upd  out  one-cycle pulse in the cycle after q was written
//   owner  out  [1:0]  index of the requester that last wrote q
//   busy   out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   q,
    output logic               q_upd,
    output logic [1:0]         owner,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The hold counter counts down to zero, so the last HOLD cycle is the one
    // in which the counter reads zero; loading HOLD_CYC-1 yields exactly
    // HOLD_CYC cycles in HOLD.
    localparam logic [3:0] HOLD_LOAD = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    state_t           state_reg, state_next;
    logic [3:0]       gnt_reg, gnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             q_upd_reg, q_upd_next;
    logic [1:0]       owner_reg, owner_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [1:0]       win_reg, win_next;
    logic [3:0]       hold_cnt_reg, hold_cnt_next;

    // -------------------------------------------------------------------------
    // Unpacked view of the write data and a request vector rotated so that
    // bit 0 is the requester the round-robin pointer currently favours.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] wdata_arr [4];
    logic [3:0]       req_rot;
    logic [1:0]       rot_off;
    logic [1:0]       win_idx;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
            // 2-bit addition wraps modulo 4, giving the circular scan order.
            assign req_rot[gi]   = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the first requester at or after
    // the pointer; adding the pointer back converts it to an absolute index.
    always_comb begin
        rot_off = 2'd0;
        if (req_rot[0])      rot_off = 2'd0;
        else if (req_rot[1]) rot_off = 2'd1;
        else if (req_rot[2]) rot_off = 2'd2;
        else if (req_rot[3]) rot_off = 2'd3;
    end

    assign win_idx = ptr_reg + rot_off;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|req) state_next = GRANT;
            end
            GRANT: begin
                state_next = (HOLD_CYC == 0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (hold_cnt_reg == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values. Everything holds by default; q,
    // owner and ptr only move on the edge that ends GRANT.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_next      = 4'b0000;
        q_next        = q_reg;
        q_upd_next    = 1'b0;
        owner_next    = owner_reg;
        ptr_next      = ptr_reg;
        win_next      = win_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next = 4'b0001 << win_idx;
                    win_next = win_idx;
                end
            end
            GRANT: begin
                // The grant is already committed: the write happens whether
                // or not the winner still requests, with data sampled now.
                q_next        = wdata_arr[win_reg];
                owner_next    = win_reg;
                ptr_next      = win_reg + 2'd1;
                q_upd_next    = 1'b1;
                hold_cnt_next = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_reg != 4'd0) hold_cnt_next = hold_cnt_reg - 4'd1;
            end
            default: begin
                gnt_next = 4'b0000;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Reset clears a pending write as well, so a reset
    // landing during GRANT cancels it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_reg      <= 4'b0000;
            q_reg        <= '0;
            q_upd_reg    <= 1'b0;
            owner_reg    <= 2'd0;
            ptr_reg      <= 2'd0;
            win_reg      <= 2'd0;
            hold_cnt_reg <= 4'd0;
        end else begin
            gnt_reg      <= gnt_next;
            q_reg        <= q_next;
            q_upd_reg    <= q_upd_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            win_reg      <= win_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt   = gnt_reg;
    assign q     = q_reg;
    assign q_upd = q_upd_reg;
    assign owner = owner_reg;
    assign busy  = (state_reg != IDLE);

endmodule
